// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calculator port initiator.
//   cmd_e / resp_e : port command and response codes
//   state_e        : port driver FSM phases
//   req_t / res_t  : port request beat and returned result
package calc_pkg;

  localparam int TAG_W = 2;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OK   = 2'd1,
    OVF  = 2'd2,
    INV  = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP1  = 2'd1,
    S_OP2  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]       cmd;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [1:0]       resp;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic [3:0]       cmd;
  } res_t;

endpackage

// File: rtl/calc_tag_pool.sv
// calc_tag_pool: free-mask tracker for outstanding request tags.
//   alloc / alloc_tag  : claim the lowest-numbered free tag
//   free / free_tag    : return a tag to the pool
//   chk_tag / chk_busy : outstanding lookup for response matching
//   any_free / any_busy: pool summary
module calc_tag_pool
  import calc_pkg::*;
#(
  parameter int NUM_TAGS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alloc,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             free,
  input  logic [TAG_W-1:0] free_tag,
  input  logic [TAG_W-1:0] chk_tag,
  output logic             chk_busy,
  output logic             any_free,
  output logic             any_busy
);

  logic [NUM_TAGS-1:0] free_q, free_d;

  // Scan downward so the lowest free index wins.
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--)
      if (free_q[i]) alloc_tag = TAG_W'(i);
  end

  assign any_free = |free_q;
  assign any_busy = ~&free_q;
  assign chk_busy = ~free_q[chk_tag];

  // Alloc and free never target the same tag: alloc picks a free tag,
  // free only acts on a busy one.
  always_comb begin
    free_d = free_q;
    if (alloc) free_d[alloc_tag] = 1'b0;
    if (free)  free_d[free_tag]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) free_q <= '1;
    else          free_q <= free_d;
  end

endmodule

// File: rtl/calc_port_driver.sv
// calc_port_driver: initiator for one calculator port.
//   in_*        : upstream valid/ready operation source
//   req_*_in    : two-beat command/operand sequence onto the port
//   out_*       : port responses, matched by tag
//   res_*       : one-cycle result pulse carrying the original command
//   busy/err*   : tag occupancy and saturating unmatched-response count
module calc_port_driver
  import calc_pkg::*;
#(
  parameter int NUM_TAGS = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cmd,
  input  logic [31:0]      in_op1,
  input  logic [31:0]      in_op2,
  output logic [3:0]       req_cmd_in,
  output logic [31:0]      req_data_in,
  output logic [TAG_W-1:0] req_tag_in,
  input  logic [1:0]       out_resp,
  input  logic [31:0]      out_data,
  input  logic [TAG_W-1:0] out_tag,
  output logic             res_valid,
  output logic [1:0]       res_resp,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [3:0]       res_cmd,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err
);

  state_e           state_q;
  req_t             req_q;
  res_t             res_q;
  logic             res_valid_q;
  logic [31:0]      op2_q;
  logic [3:0]       cmd_table_q [NUM_TAGS];
  logic [ERR_W-1:0] err_cnt_q;

  logic             any_free, any_busy, chk_busy;
  logic [TAG_W-1:0] alloc_tag;
  logic             accept, issue, rsp_vld, matched, unmatched;

  // OP2 is the last port beat, so a new OP1 may follow it directly; this
  // is what gives the two-cycle issue rate. Gating with reset_n keeps
  // ready low while the block is held in reset.
  assign in_ready  = reset_n && any_free && (state_q != S_OP1);
  assign accept    = in_valid && in_ready;
  assign issue     = accept && (in_cmd != NOP);
  assign rsp_vld   = (out_resp != NONE);
  assign matched   = rsp_vld && chk_busy;
  assign unmatched = rsp_vld && !chk_busy;

  calc_tag_pool #(.NUM_TAGS(NUM_TAGS)) u_pool (
    .clk      (clk),
    .reset_n  (reset_n),
    .alloc    (issue),
    .alloc_tag(alloc_tag),
    .free     (matched),
    .free_tag (out_tag),
    .chk_tag  (out_tag),
    .chk_busy (chk_busy),
    .any_free (any_free),
    .any_busy (any_busy)
  );

  // Port sequencing; state_q names the beat currently on the port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      op2_q   <= '0;
      for (int i = 0; i < NUM_TAGS; i++) cmd_table_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_OP2: begin
          if (issue) begin
            state_q                <= S_OP1;
            req_q                  <= '{cmd: in_cmd, data: in_op1, tag: alloc_tag};
            op2_q                  <= in_op2;
            cmd_table_q[alloc_tag] <= in_cmd;
          end else begin
            state_q <= S_IDLE;
            req_q   <= '0;
          end
        end
        S_OP1: begin
          state_q <= S_OP2;
          req_q   <= '{cmd: 4'd0, data: op2_q, tag: req_q.tag};
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= '0;
        end
      endcase
    end
  end

  // Response capture and unmatched-response accounting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      res_valid_q <= matched;
      if (matched)
        res_q <= '{resp: out_resp, data: out_data, tag: out_tag,
                   cmd: cmd_table_q[out_tag]};
      if (unmatched && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign req_cmd_in  = req_q.cmd;
  assign req_data_in = req_q.data;
  assign req_tag_in  = req_q.tag;
  assign res_valid   = res_valid_q;
  assign res_resp    = res_q.resp;
  assign res_data    = res_q.data;
  assign res_tag     = res_q.tag;
  assign res_cmd     = res_q.cmd;
  assign busy        = any_busy;
  assign err_cnt     = err_cnt_q;
  assign err         = (err_cnt_q != '0);

endmodule

// File: tb/tb_calc_port_driver.sv
// tb_calc_port_driver: directed bench for calc_port_driver with a result
// scoreboard (expected results queued at response time, popped on res_valid).
module tb_calc_port_driver;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_op1 = '0, in_op2 = '0;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp = '0;
  logic [31:0] out_data = '0;
  logic [1:0]  out_tag = '0;
  logic        res_valid;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic [1:0]  res_tag;
  logic [3:0]  res_cmd;
  logic        busy;
  logic [7:0]  err_cnt;
  logic        err;

  calc_port_driver #(.NUM_TAGS(4), .ERR_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .res_valid(res_valid), .res_resp(res_resp), .res_data(res_data),
    .res_tag(res_tag), .res_cmd(res_cmd),
    .busy(busy), .err_cnt(err_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [39:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every res_valid pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) check("res_unexpected", 64'(res_valid), 64'd0);
      else check("res", 64'({res_resp, res_data, res_tag, res_cmd}), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op and check both port beats; acc = cycle of accept edge.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] et, output int acc);
    in_valid = 1'b1; in_cmd = c; in_op1 = a; in_op2 = b;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    check("send_ready", 64'(in_ready), 64'd1);
    tick();
    acc = cyc;
    in_valid = 1'b0;
    check("op1_cmd", 64'(req_cmd_in), 64'(c));
    check("op1_data", 64'(req_data_in), 64'(a));
    check("op1_tag", 64'(req_tag_in), 64'(et));
    tick();
    check("op2_cmd", 64'(req_cmd_in), 64'd0);
    check("op2_data", 64'(req_data_in), 64'(b));
    check("op2_tag", 64'(req_tag_in), 64'(et));
  endtask

  // One response cycle; if a match is expected, queue the result.
  task automatic respond(input logic [1:0] t, input logic [1:0] r, input logic [31:0] d,
                         input bit match, input logic [3:0] c);
    out_resp = r; out_data = d; out_tag = t;
    if (match) exp_q.push_back({r, d, t, c});
    tick();
    out_resp = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, a4, a5;

    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_req_cmd", 64'(req_cmd_in), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);

    // NOP is consumed without driving the port
    tick();
    in_valid = 1'b1; in_cmd = 4'd0; in_op1 = 32'hFFFF; in_op2 = 32'hEEEE;
    tick();
    in_valid = 1'b0;
    check("nop_cmd", 64'(req_cmd_in), 64'd0);
    check("nop_data", 64'(req_data_in), 64'd0);
    check("nop_busy", 64'(busy), 64'd0);

    // ADD 5+3
    send(4'd1, 32'd5, 32'd3, 2'd0, a0);
    tick();
    check("idle_data", 64'(req_data_in), 64'd0);
    check("add_busy", 64'(busy), 64'd1);
    respond(2'd0, 2'd1, 32'd8, 1'b1, 4'd1);
    tick();
    check("add_freed", 64'(busy), 64'd0);

    // Four back-to-back ops fill every tag
    send(4'd1, 32'h10, 32'h11, 2'd0, a0);
    send(4'd2, 32'h20, 32'h21, 2'd1, a1);
    send(4'd5, 32'h30, 32'h31, 2'd2, a2);
    send(4'd6, 32'h40, 32'h41, 2'd3, a3);
    check("b2b_gap1", 64'(a1 - a0), 64'd2);
    check("b2b_gap2", 64'(a2 - a1), 64'd2);
    check("b2b_gap3", 64'(a3 - a2), 64'd2);
    check("full_ready", 64'(in_ready), 64'd0);
    tick();
    check("full_ready_idle", 64'(in_ready), 64'd0);

    // Freeing tag 2 re-raises ready the following cycle
    out_resp = 2'd1; out_data = 32'h22; out_tag = 2'd2;
    exp_q.push_back({2'd1, 32'h22, 2'd2, 4'd5});
    #1;
    check("free_cycle_ready", 64'(in_ready), 64'd0);
    tick();
    out_resp = '0;
    check("freed_ready", 64'(in_ready), 64'd1);
    send(4'd9, 32'h90, 32'h91, 2'd2, a4);

    // Free of tag 0 coincides with an offered op while full
    in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'hA0; in_op2 = 32'hA1;
    out_resp = 2'd2; out_data = 32'hDEAD; out_tag = 2'd0;
    exp_q.push_back({2'd2, 32'hDEAD, 2'd0, 4'd1});
    #1;
    check("simul_ready", 64'(in_ready), 64'd0);
    tick();
    out_resp = '0;
    check("simul_not_taken", 64'(req_cmd_in), 64'd0);
    check("simul_ready_next", 64'(in_ready), 64'd1);
    send(4'd1, 32'hA0, 32'hA1, 2'd0, a5);
    tick();

    // Drain every outstanding tag
    respond(2'd0, 2'd1, 32'h100, 1'b1, 4'd1);
    respond(2'd1, 2'd3, 32'h101, 1'b1, 4'd2);
    respond(2'd2, 2'd3, 32'h102, 1'b1, 4'd9);
    respond(2'd3, 2'd1, 32'h103, 1'b1, 4'd6);
    tick();
    check("drained_busy", 64'(busy), 64'd0);

    // Response to a free tag
    respond(2'd1, 2'd1, 32'h55, 1'b0, 4'd0);
    check("unmatched_cnt", 64'(err_cnt), 64'd1);
    check("unmatched_err", 64'(err), 64'd1);

    // Reset during OP1
    in_valid = 1'b1; in_cmd = 4'd2; in_op1 = 32'd7; in_op2 = 32'd1;
    tick();
    in_valid = 1'b0;
    check("pre_rst_op1", 64'(req_cmd_in), 64'd2);
    #2 reset_n = 1'b0;
    #1;
    check("async_cmd", 64'(req_cmd_in), 64'd0);
    check("async_data", 64'(req_data_in), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_ready", 64'(in_ready), 64'd0);
    check("async_err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("rerst_ready", 64'(in_ready), 64'd1);
    respond(2'd0, 2'd1, 32'd6, 1'b0, 4'd0);
    check("stale_tag_cnt", 64'(err_cnt), 64'd1);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      out_resp = 2'(1 + (i % 3)); out_tag = 2'(i); out_data = 32'(i);
      tick();
    end
    out_resp = '0;
    check("sat_cnt", 64'(err_cnt), 64'd255);
    check("sat_err", 64'(err), 64'd1);

    tick(); tick(); tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
